// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit FSM states, line constants
// and the baud divisor helper used by both line directions.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS  = 8;

  // Rounded clocks per bit.
  function automatic int calc_div(
    input int clk_hz,
    input int baud
  );
    return (clk_hz + baud / 2) / baud;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy and a
// combinational head read.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wp;
  logic [AW-1:0]    r_rp;
  logic [AW:0]      r_cnt;
  logic             w_wr;
  logic             w_rd;

  assign full    = (r_cnt == FULL_CNT);
  assign empty   = (r_cnt == '0);
  assign count   = r_cnt;
  assign rd_data = r_mem[r_rp];

  // Full/empty come from the pre-edge count, so a write
  // into a full FIFO is dropped even alongside a pop.
  assign w_wr = wr_en && !full;
  assign w_rd = rd_en && !empty;

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + AW'(1);
      if (w_rd) r_rp <= r_rp + AW'(1);
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_buf.sv
// Buffered 8N1 transmitter: FIFO drained back-to-back onto tx.
// Define UART_TX_PARITY_EN for 8E1/8O1 frames (parameter ODD).
module uart_tx_buf
  import uart_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200,
`ifdef UART_TX_PARITY_EN
  parameter bit ODD    = 1'b0,
`endif
  parameter int DEPTH  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [7:0]             data,
  input  logic                   we,
  output logic                   full,
  output logic                   empty,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] count,
  output logic                   tx
);

  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int TW  = $clog2(DIV);
  localparam logic [TW-1:0] TMR_LOAD = TW'(DIV - 1);
  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  tx_state_t     r_state;
  tx_state_t     w_state_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic [TW-1:0] r_tmr;
  logic [TW-1:0] w_tmr_nxt;
  logic [2:0]    r_idx;
  logic [2:0]    w_idx_nxt;
  logic          r_tx;
  logic          w_tx_nxt;
  logic          w_pop;
  logic          w_tmr_end;
  logic [7:0]    w_byte;
`ifdef UART_TX_PARITY_EN
  logic          r_par;
  logic          w_par_nxt;
`endif

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (we),
    .wr_data (data),
    .rd_en   (w_pop),
    .rd_data (w_byte),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  assign w_tmr_end = (r_tmr == '0);
  assign tx        = r_tx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_tmr   <= '0;
      r_idx   <= '0;
      r_tx    <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nxt;
      r_shift <= w_shift_nxt;
      r_tmr   <= w_tmr_nxt;
      r_idx   <= w_idx_nxt;
      r_tx    <= w_tx_nxt;
`ifdef UART_TX_PARITY_EN
      r_par   <= w_par_nxt;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_tmr_nxt   = r_tmr;
    w_idx_nxt   = r_idx;
    w_tx_nxt    = r_tx;
`ifdef UART_TX_PARITY_EN
    w_par_nxt   = r_par;
`endif
    if (w_pop) begin
      w_state_nxt = START;
      w_shift_nxt = w_byte;
      w_tmr_nxt   = TMR_LOAD;
      w_idx_nxt   = '0;
      w_tx_nxt    = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_nxt   = (^w_byte) ^ ODD;
`endif
    end else if (r_state == IDLE) begin
      w_tx_nxt = IDLE_LEVEL;
    end else if (!w_tmr_end) begin
      w_tmr_nxt = r_tmr - TW'(1);
    end else begin
      // Reload at every bit boundary so timing never drifts.
      w_tmr_nxt = TMR_LOAD;
      unique case (r_state)
        START: begin
          w_state_nxt = DATA;
          w_idx_nxt   = '0;
          w_tx_nxt    = r_shift[0];
        end
        DATA: begin
          if (r_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            w_state_nxt = PARITY;
            w_tx_nxt    = r_par;
`else
            w_state_nxt = STOP;
            w_tx_nxt    = IDLE_LEVEL;
`endif
          end else begin
            w_shift_nxt = r_shift >> 1;
            w_idx_nxt   = r_idx + 3'd1;
            w_tx_nxt    = r_shift[1];
          end
        end
        PARITY: begin
          w_state_nxt = STOP;
          w_tx_nxt    = IDLE_LEVEL;
        end
        default: begin
          w_state_nxt = IDLE;
          w_tx_nxt    = IDLE_LEVEL;
        end
      endcase
    end
  end

  always_comb begin
    w_pop = 1'b0;
    busy  = (r_state != IDLE);
    unique case (r_state)
      IDLE:    w_pop = !empty;
      STOP:    w_pop = w_tmr_end && !empty;
      default: w_pop = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_buf.sv
// Bench for uart_tx_buf: directed writes, per-cycle tx waveform
// checks and a line-decoding monitor fed from an expected-byte queue.
module tb_uart_tx_buf;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 100_000;
  localparam int DEPTH  = 4;
  localparam int DIV    = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       we  = 1'b0;
  logic [7:0] data = 8'h00;
  logic       full;
  logic       empty;
  logic       busy;
  logic       tx;
  logic [2:0] count;

  int   cyc    = 0;
  int   n_pass = 0;
  int   n_tot  = 0;
  bit   abort  = 1'b0;

  logic [7:0] exp_q [$];
  logic       wq    [$];
  logic [7:0] dbv   [6];
  int         dcnt  [6];

  uart_tx_buf #(
    .CLK_HZ (CLK_HZ),
    .BAUD   (BAUD),
`ifdef UART_TX_PARITY_EN
    .ODD    (1'b0),
`endif
    .DEPTH  (DEPTH)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .data  (data),
    .we    (we),
    .full  (full),
    .empty (empty),
    .busy  (busy),
    .count (count),
    .tx    (tx)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(
    input string       nm,
    input logic [31:0] act,
    input logic [31:0] exp
  );
    n_tot++;
    if (act !== exp)
      $display("FAIL %s: got %0h want %0h (cyc %0d)",
               nm, act, exp, cyc);
    else
      n_pass++;
  endtask

  // Queue a byte for the monitor and its bit-period levels
  // for the waveform checker.
  task automatic push_frame(input logic [7:0] b);
    exp_q.push_back(b);
    wq.push_back(1'b0);
    for (int i = 0; i < 8; i++) wq.push_back(b[i]);
`ifdef UART_TX_PARITY_EN
    wq.push_back(^b);
`endif
    wq.push_back(1'b1);
  endtask

  // n0 is the cycle count just after the first write edge.
  task automatic wave(
    input int    n0,
    input string nm,
    input bit    chk_empty
  );
    int L;
    int k;
    L = wq.size() * DIV;
    do begin
      @(negedge clk);
      k = cyc - n0;
      if (k >= 1 && k <= L) begin
        chk({nm, "_tx"}, tx, wq[(k - 1) / DIV]);
        chk({nm, "_busy"}, busy, 1);
        if (chk_empty) chk({nm, "_empty"}, empty, 1);
      end
    end while (k <= L);
    chk({nm, "_busy_end"}, busy, 0);
    chk({nm, "_tx_end"}, tx, 1);
    wq.delete();
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_drained"}, exp_q.size(), 0);
    chk({nm, "_idle"}, busy, 0);
  endtask

  // Line receiver: mid-bit sampling from the first low sample.
  initial begin : mon
    logic [7:0] b;
    logic       s0;
    logic       sp;
`ifdef UART_TX_PARITY_EN
    logic       p;
`endif
    forever begin
      @(negedge clk);
      if (rst && tx == 1'b0) begin
        repeat (DIV / 2) @(negedge clk);
        s0 = tx;
        for (int i = 0; i < 8; i++) begin
          repeat (DIV) @(negedge clk);
          b[i] = tx;
        end
`ifdef UART_TX_PARITY_EN
        repeat (DIV) @(negedge clk);
        p = tx;
`endif
        repeat (DIV) @(negedge clk);
        sp = tx;
        if (abort) begin
          abort = 1'b0;
        end else if (exp_q.size() == 0) begin
          n_tot++;
          $display("FAIL rx_unexpected: got %0h want none", b);
        end else begin
          chk("rx_byte", b, exp_q.pop_front());
          chk("rx_start", s0, 0);
          chk("rx_stop", sp, 1);
`ifdef UART_TX_PARITY_EN
          chk("rx_par", p, ^b);
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int n0;
    dbv  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    dcnt = '{1, 1, 2, 3, 4, 4};

    @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_count", count, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      chk("idle_tx", tx, 1);
      chk("idle_busy", busy, 0);
      chk("idle_empty", empty, 1);
      chk("idle_count", count, 0);
    end

    // Single byte.
    n0 = cyc + 1;
    data = 8'hA5;
    we = 1'b1;
    push_frame(8'hA5);
    fork
      begin @(negedge clk); we = 1'b0; end
      wave(n0, "single", 1'b1);
    join
    drain("single");

    // Three back-to-back frames.
    @(negedge clk);
    n0 = cyc + 1;
    data = 8'h00;
    we = 1'b1;
    push_frame(8'h00);
    push_frame(8'hFF);
    push_frame(8'h3C);
    fork
      begin
        @(negedge clk); data = 8'hFF;
        @(negedge clk); data = 8'h3C;
        @(negedge clk); we = 1'b0;
      end
      wave(n0, "b2b", 1'b0);
    join
    drain("b2b");

    // Overfill: sixth byte is dropped.
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i > 0) chk("depth_count", count, dcnt[i - 1]);
      data = dbv[i];
      we = 1'b1;
      if (i < 5) exp_q.push_back(dbv[i]);
      @(negedge clk);
    end
    we = 1'b0;
    chk("depth_count_last", count, dcnt[5]);
    chk("depth_full", full, 1);
    drain("depth");

    // Reset mid-frame, with a second byte still queued.
    @(negedge clk);
    n0 = cyc + 1;
    data = 8'h81;
    we = 1'b1;
    exp_q.push_back(8'h81);
    @(negedge clk);
    data = 8'h42;
    @(negedge clk);
    we = 1'b0;
    while (cyc - n0 < 35) @(negedge clk);
    chk("abort_tx_low", tx, 0);
    abort = 1'b1;
    exp_q.delete();
    rst = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_count", count, 0);
    chk("abort_busy", busy, 0);
    chk("abort_empty", empty, 1);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      chk("post_rst_tx", tx, 1);
    end
    abort = 1'b0;
    n0 = cyc + 1;
    data = 8'h55;
    we = 1'b1;
    push_frame(8'h55);
    fork
      begin @(negedge clk); we = 1'b0; end
      wave(n0, "post_rst", 1'b1);
    join
    drain("post_rst");

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    n0 = cyc + 1;
    data = 8'h07;
    we = 1'b1;
    push_frame(8'h07);
    chk("par_bit", wq[9], 1);
    fork
      begin @(negedge clk); we = 1'b0; end
      wave(n0, "par", 1'b1);
    join
    drain("par");
`endif

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
